multiplicador_mac_sat: RTL

Pipelined, parametrised signed fixed-point multiply / multiply-accumulate unit with true-range saturation. Operands and result use the same Qm.f format: 1 sign bit, MAG integer bits, PRES fraction bits. It succeeds the combinational saturating multiplier in the arithmetic datapath, adding:
- valid/ready flow control
- optional rounding
- an accumulate mode
- per-sample and sticky saturation flags

---
 rtl/multiplicador_mac_sat.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/multiplicador_mac_sat.sv
// multiplicador_mac_sat
// Two-stage pipelined signed fixed-point multiply / multiply-accumulate unit
// with saturation to the true data range. Operands and result share the same
// Q format: 1 sign bit, MAG integer bits and PRES fraction bits.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   a, b                signed operands
//   modo                0 = multiply, 1 = multiply-accumulate
//   clr_acc             MAC sample uses 0 instead of the accumulator
//   in_valid/in_ready   input handshake
//   y, y_valid/y_ready  saturated result and output handshake
//   ovf, unf            result saturated positive / negative (aligned with y)
//   sat_sticky          set by any flagged result, cleared by clr_sticky
//   clr_sticky          synchronous clear of sat_sticky (wins over a set)
module multiplicador_mac_sat #(
  parameter int LARGO    = 24,
  parameter int MAG      = 8,
  parameter int PRES     = 16,
  parameter int REDONDEO = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [LARGO:0] a,
  input  logic signed [LARGO:0] b,
  input  logic               modo,
  input  logic               clr_acc,
  input  logic               in_valid,
  output logic               in_ready,
  output logic signed [LARGO:0] y,
  output logic               y_valid,
  input  logic               y_ready,
  output logic               ovf,
  output logic               unf,
  output logic               sat_sticky,
  input  logic               clr_sticky
);

  localparam int W  = LARGO + 1;
  localparam int PW = 2 * W;

  if (LARGO != MAG + PRES) begin : g_bad_format
    $error("multiplicador_mac_sat: LARGO must equal MAG + PRES");
  end

  // Limits at the three widths used: scaled product, result, MAC sum.
  localparam logic signed [PW:0]    MAXF = {{(PW + 1 - LARGO){1'b0}}, {LARGO{1'b1}}};
  localparam logic signed [PW:0]    MINF = {{(PW + 1 - LARGO){1'b1}}, {LARGO{1'b0}}};
  localparam logic signed [LARGO:0] MAXW = {1'b0, {LARGO{1'b1}}};
  localparam logic signed [LARGO:0] MINW = {1'b1, {LARGO{1'b0}}};
  localparam logic signed [W:0]     MAXS = {2'b00, {LARGO{1'b1}}};
  localparam logic signed [W:0]     MINS = {2'b11, {LARGO{1'b0}}};
  localparam logic signed [PW:0]    RND  = (REDONDEO != 0) ? ((PW + 1)'(1) << (PRES - 1)) : '0;

  logic signed [PW-1:0] p1;
  logic                 m1, c1, v1, v2;
  logic signed [LARGO:0] acc;
  logic                 adv1, adv2;

  logic signed [PW:0]    p_ext, s_full;
  logic signed [LARGO:0] ms, base, r, nxt_y;
  logic signed [W:0]     sum;
  logic                  o1, u1, o2, u2, nxt_ovf, nxt_unf;

  assign adv2     = !v2 || y_ready;
  assign adv1     = !v1 || adv2;
  assign in_ready = adv1;
  assign y_valid  = v2;

  always_comb begin
    // One extra bit keeps the rounding add from wrapping at the extreme product.
    p_ext  = {p1[PW-1], p1} + RND;
    s_full = p_ext >>> PRES;

    o1 = 1'b0;
    u1 = 1'b0;
    if (s_full > MAXF) begin
      ms = MAXW;
      o1 = 1'b1;
    end else if (s_full < MINF) begin
      ms = MINW;
      u1 = 1'b1;
    end else begin
      ms = s_full[LARGO:0];
    end

    base = c1 ? '0 : acc;
    sum  = {base[LARGO], base} + {ms[LARGO], ms};
    o2 = 1'b0;
    u2 = 1'b0;
    if (sum > MAXS) begin
      r  = MAXW;
      o2 = 1'b1;
    end else if (sum < MINS) begin
      r  = MINW;
      u2 = 1'b1;
    end else begin
      r = sum[LARGO:0];
    end

    nxt_y   = m1 ? r : ms;
    nxt_ovf = o1 || (m1 && o2);
    nxt_unf = u1 || (m1 && u2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1 <= '0;
      m1 <= 1'b0;
      c1 <= 1'b0;
      v1 <= 1'b0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        // Sign-extend to full product width so the low PW bits are exact.
        p1 <= $signed({{W{a[LARGO]}}, a}) * $signed({{W{b[LARGO]}}, b});
        m1 <= modo;
        c1 <= clr_acc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2  <= 1'b0;
      y   <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
      acc <= '0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        y   <= nxt_y;
        ovf <= nxt_ovf;
        unf <= nxt_unf;
        if (m1) acc <= r;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_sticky <= 1'b0;
    end else if (clr_sticky) begin
      sat_sticky <= 1'b0;
    end else if (adv2 && v1 && (nxt_ovf || nxt_unf)) begin
      sat_sticky <= 1'b1;
    end
  end

endmodule
